// File: rtl/i2s_pkg.sv
// Shared I2S transmitter definitions: default frame geometry, stereo sample
// container and channel encoding for the lrck level.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W = 24;
    localparam int unsigned I2S_SLOT_W = 32;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] left;
        logic [I2S_DATA_W-1:0] right;
    } stereo_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchronizer for an asynchronous clock-like input, with a third
// flop so single-cycle rise/fall pulses can be derived in the clk domain.
module i2s_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_stereo_tx.sv
// I2S stereo transmitter slaved to external bck/lrck: one-deep holding
// register feeding per-channel shift registers reloaded at each frame start.
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = I2S_DATA_W,
    parameter int unsigned SLOT_W = I2S_SLOT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bck_in,
    input  logic              lrck_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              sdata,
    output logic              underrun
);

    localparam int unsigned      CNT_W   = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W - 1);

    logic bck_level_unused, bck_rise_unused, bck_fall;
    logic lrck_level, lrck_rise, lrck_fall;

    i2s_edge_sync u_bck_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bck_in),
        .level    (bck_level_unused),
        .rise     (bck_rise_unused),
        .fall     (bck_fall)
    );

    i2s_edge_sync u_lrck_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (lrck_in),
        .level    (lrck_level),
        .rise     (lrck_rise),
        .fall     (lrck_fall)
    );

    logic [DATA_W-1:0] hold_left_q,   hold_left_d;
    logic [DATA_W-1:0] hold_right_q,  hold_right_d;
    logic [DATA_W-1:0] shift_left_q,  shift_left_d;
    logic [DATA_W-1:0] shift_right_q, shift_right_d;
    logic [CNT_W-1:0]  bit_cnt_q,     bit_cnt_d;
    logic              hold_full_q,   hold_full_d;
    logic              s_ready_q,     s_ready_d;
    logic              sdata_q,       sdata_d;
    logic              underrun_q,    underrun_d;
    logic              armed_q,       armed_d;

    logic  accept;
    logic  slot_start;
    logic  msb;
    chan_e chan;

    assign accept     = s_valid && s_ready_q;
    assign slot_start = bck_fall && (lrck_rise || lrck_fall);
    assign chan       = chan_e'(lrck_level);

    always_comb begin
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;
        shift_left_d  = shift_left_q;
        shift_right_d = shift_right_q;
        bit_cnt_d     = bit_cnt_q;
        hold_full_d   = hold_full_q;
        sdata_d       = sdata_q;
        armed_d       = armed_q;
        underrun_d    = 1'b0;
        msb           = 1'b0;

        if (accept) begin
            hold_left_d  = s_left;
            hold_right_d = s_right;
            hold_full_d  = 1'b1;
        end

        // The bit after an lrck edge is the I2S delay slot, so nothing shifts.
        if (slot_start) begin
            bit_cnt_d = '0;
            sdata_d   = 1'b0;
        end else if (bck_fall) begin
            if (chan == CH_LEFT) begin
                msb          = shift_left_q[DATA_W-1];
                shift_left_d = {shift_left_q[DATA_W-2:0], 1'b0};
            end else begin
                msb           = shift_right_q[DATA_W-1];
                shift_right_d = {shift_right_q[DATA_W-2:0], 1'b0};
            end
            sdata_d = armed_q && msb && (32'(bit_cnt_q) < DATA_W);
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        // Frame load sits after the shift so it wins if both land together;
        // a same-cycle accept only ever refills an empty holding register.
        if (lrck_fall) begin
            armed_d = 1'b1;
            if (hold_full_q) begin
                shift_left_d  = hold_left_q;
                shift_right_d = hold_right_q;
                hold_full_d   = 1'b0;
            end else begin
                shift_left_d  = '0;
                shift_right_d = '0;
                underrun_d    = 1'b1;
            end
        end

        s_ready_d = !hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            shift_left_q  <= '0;
            shift_right_q <= '0;
            bit_cnt_q     <= '0;
            hold_full_q   <= 1'b0;
            s_ready_q     <= 1'b0;
            sdata_q       <= 1'b0;
            underrun_q    <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
            shift_left_q  <= shift_left_d;
            shift_right_q <= shift_right_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_full_q   <= hold_full_d;
            s_ready_q     <= s_ready_d;
            sdata_q       <= sdata_d;
            underrun_q    <= underrun_d;
            armed_q       <= armed_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx: bck = clk/16, lrck = bck/64, every frame's
// sdata sampled on bck rises and compared with hand-built slot images.
module tb_i2s_stereo_tx;
    import i2s_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bck_in = 1'b0;
    logic        lrck_in = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        sdata;
    logic        underrun;

    i2s_stereo_tx #(.DATA_W(24), .SLOT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .bck_in   (bck_in),
        .lrck_in  (lrck_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .sdata    (sdata),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          div = 0;
    int          bpos = 40;
    int          frame_no = 0;
    int          frame_done = -1;
    int          acc_cnt = 0;
    int          pre_ones = 0;
    logic [63:0] word = '0;
    logic [63:0] frame_log [0:15];
    int          ur_log [0:15];

    initial begin
        for (int i = 0; i < 16; i++) begin
            frame_log[i] = '0;
            ur_log[i] = 0;
        end
    end

    // bck/lrck source; lrck changes on bck falls, sdata sampled on bck rises
    always @(negedge clk) begin
        div++;
        if (div == 8) begin
            div = 0;
            if (bck_in) begin
                bck_in = 1'b0;
                bpos = (bpos + 1) % 64;
                lrck_in = (bpos >= 32);
                if (bpos == 0) frame_no++;
            end else begin
                bck_in = 1'b1;
                word[63-bpos] = sdata;
                if (bpos == 63 && frame_no < 16) begin
                    frame_log[frame_no] = word;
                    frame_done = frame_no;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (underrun && frame_no < 16) ur_log[frame_no]++;
        if (frame_no == 0 && sdata) pre_ones++;
    end

    always @(posedge clk) begin
        if (!reset && s_valid && s_ready) acc_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input stereo_t s);
        return {1'b0, s.left, 7'b0, 1'b0, s.right, 7'b0};
    endfunction

    task automatic offer(input stereo_t s);
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = s.left;
        s_right = s.right;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input int n);
        int t = 0;
        while (frame_done < n && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check($sformatf("wait_frame%0d", n), 64'(frame_done >= n), 64'd1);
    endtask

    task automatic wait_pos(input int f, input int p);
        int t = 0;
        while (!(frame_no == f && bpos >= p) && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check($sformatf("wait_f%0d_b%0d", f, p), 64'(frame_no == f && bpos >= p), 64'd1);
    endtask

    task automatic check_frame(input int f, input stereo_t s, input int ur);
        logic [63:0] e;
        e = exp_frame(s);
        check($sformatf("frame%0d_left", f),  {32'd0, frame_log[f][63:32]}, {32'd0, e[63:32]});
        check($sformatf("frame%0d_right", f), {32'd0, frame_log[f][31:0]},  {32'd0, e[31:0]});
        check($sformatf("frame%0d_underruns", f), 64'(ur_log[f]), 64'(ur));
    endtask

    initial begin
        stereo_t s0, sw, sx, sy, sz, zero_s, sk;
        int acc0, last, k, t;
        s0     = '{left: 24'hA5F00F, right: 24'h123456};
        sw     = '{left: 24'h800001, right: 24'h7FFFFE};
        sx     = '{left: 24'hFFFFFF, right: 24'h000001};
        sy     = '{left: 24'h0F0F0F, right: 24'hF0F0F0};
        sz     = '{left: 24'h5A5A5A, right: 24'hC3C3C3};
        zero_s = '0;

        // reset state and release
        repeat (4) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_sdata", 64'(sdata), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_s_ready", 64'(s_ready), 64'd1);

        // first sample accepted before the first lrck fall
        offer(s0);
        check("accept_s_ready_low", 64'(s_ready), 64'd0);
        wait_frame_done(1);
        check("prearm_sdata_ones", 64'(pre_ones), 64'd0);
        check("prearm_underruns", 64'(ur_log[0]), 64'd0);
        check("prearm_frame_bits", frame_log[0], 64'd0);
        check_frame(1, s0, 0);

        // three frames with no sample: one underrun each, silent output
        wait_frame_done(4);
        for (int f = 2; f <= 4; f++) check_frame(f, zero_s, 1);

        // sample offered in the very cycle the lrck fall is detected
        t = 0;
        while (frame_no < 5 && t < 400) begin
            @(posedge clk);
            t++;
        end
        check("wait_lrck_fall5", 64'(frame_no >= 5), 64'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = sw.left;
        s_right = sw.right;
        @(negedge clk);
        s_valid = 1'b0;
        check("collide_underrun", 64'(underrun), 64'd1);
        check("collide_s_ready", 64'(s_ready), 64'd0);
        wait_frame_done(6);
        check_frame(5, zero_s, 1);
        check_frame(6, sw, 0);

        // s_valid held high with incrementing data: one accept per frame
        acc0 = acc_cnt;
        last = acc_cnt;
        k = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = 24'h100000;
        s_right = 24'h200000;
        t = 0;
        while (frame_done < 10 && t < 6000) begin
            @(negedge clk);
            t++;
            if (acc_cnt != last) begin
                last = acc_cnt;
                k++;
                s_left  = 24'h100000 + 24'(k);
                s_right = 24'h200000 + 24'(k);
            end
        end
        check("stream_done", 64'(frame_done >= 10), 64'd1);
        check("stream_accepts", 64'(acc_cnt - acc0), 64'd5);
        check("stream_s_ready_low", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        wait_frame_done(11);
        for (int f = 7; f <= 11; f++) begin
            sk.left  = 24'h100000 + 24'(f - 7);
            sk.right = 24'h200000 + 24'(f - 7);
            check_frame(f, sk, 0);
        end

        // reset mid left slot with a second sample waiting in the holding register
        offer(sx);
        wait_pos(12, 5);
        offer(sy);
        wait_pos(12, 10);
        repeat (5) @(posedge clk);
        #1;
        check("bit10_before_reset", 64'(sdata), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_sdata_cleared", 64'(sdata), 64'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_hold_empty", 64'(s_ready), 64'd1);
        offer(sz);
        wait_frame_done(13);
        check("frame12_right_silent", {32'd0, frame_log[12][31:0]}, 64'd0);
        check("frame12_underruns", 64'(ur_log[12]), 64'd0);
        check_frame(13, sz, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
